// File: rtl/vga_pkg.sv
// Shared timing constants and types for the 640x480 @ 60 Hz scan path.
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FP_DEF      = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BP_DEF      = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FP_DEF      = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BP_DEF      = 33;
    localparam int unsigned CLK_DIV_DEF   = 2;

    localparam int unsigned H_TOTAL  = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL  = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned HS_START = H_VISIBLE_DEF + H_FP_DEF;
    localparam int unsigned HS_END   = HS_START + H_SYNC_DEF - 1;
    localparam int unsigned VS_START = V_VISIBLE_DEF + V_FP_DEF;
    localparam int unsigned VS_END   = VS_START + V_SYNC_DEF - 1;

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/vga_scan_gen.sv
// Pixel divider, scan counters, sync/blank decode and DAC output registers.
// Also produces the per-frame strobe and frame counter used as the game tick.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FP      = H_FP_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BP      = H_BP_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FP      = V_FP_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BP      = V_BP_DEF,
    parameter int unsigned CLK_DIV   = CLK_DIV_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  Red,
    input  logic [7:0]  Green,
    input  logic [7:0]  Blue,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        pix_ce,
    output logic        frame_start,
    output logic [15:0] frame_count,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int unsigned HTotal  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HsStart = H_VISIBLE + H_FP;
    localparam int unsigned HsEnd   = HsStart + H_SYNC - 1;
    localparam int unsigned VsStart = V_VISIBLE + V_FP;
    localparam int unsigned VsEnd   = VsStart + V_SYNC - 1;
    localparam int unsigned DivW    = $clog2(CLK_DIV);

    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    coord_t          draw_x_q, draw_x_d;
    coord_t          draw_y_q, draw_y_d;
    logic            vga_clk_q;
    logic            vga_hs_q, vga_vs_q, vga_blank_n_q;
    rgb_t            rgb_q, rgb_d;
    logic            frame_start_q;
    logic [15:0]     frame_count_q;

    logic pix_ce_w;
    logic x_last, y_last, frame_wrap;
    logic hs_d, vs_d, vis_d;

    always_comb begin
        pix_ce_w   = (div_cnt_q == DivW'(CLK_DIV - 1));
        div_cnt_d  = pix_ce_w ? '0 : div_cnt_q + 1'b1;

        x_last     = (draw_x_q == coord_t'(HTotal - 1));
        y_last     = (draw_y_q == coord_t'(VTotal - 1));
        frame_wrap = pix_ce_w && x_last && y_last;

        draw_x_d = draw_x_q;
        draw_y_d = draw_y_q;
        if (pix_ce_w) begin
            if (x_last) begin
                draw_x_d = '0;
                draw_y_d = y_last ? '0 : draw_y_q + 1'b1;
            end else begin
                draw_x_d = draw_x_q + 1'b1;
            end
        end

        // Decode uses the pixel currently presented to color_mapper, so the
        // registered sync/blank line up with the registered colour.
        hs_d  = !((draw_x_q >= coord_t'(HsStart)) && (draw_x_q <= coord_t'(HsEnd)));
        vs_d  = !((draw_y_q >= coord_t'(VsStart)) && (draw_y_q <= coord_t'(VsEnd)));
        vis_d = (draw_x_q < coord_t'(H_VISIBLE)) && (draw_y_q < coord_t'(V_VISIBLE));

        rgb_d = vis_d ? rgb_t'{r: Red, g: Green, b: Blue} : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            div_cnt_q     <= '0;
            draw_x_q      <= '0;
            draw_y_q      <= '0;
            vga_clk_q     <= 1'b0;
            vga_hs_q      <= 1'b1;
            vga_vs_q      <= 1'b1;
            vga_blank_n_q <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            // One-cycle lag puts the rising edge of VGA_CLK on the pix_ce edge.
            vga_clk_q     <= (div_cnt_q >= DivW'(CLK_DIV / 2));
            draw_x_q      <= draw_x_d;
            draw_y_q      <= draw_y_d;
            frame_start_q <= frame_wrap;
            if (pix_ce_w) begin
                vga_hs_q      <= hs_d;
                vga_vs_q      <= vs_d;
                vga_blank_n_q <= vis_d;
                rgb_q         <= rgb_d;
            end
            if (frame_wrap) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    assign pix_ce      = pix_ce_w;
    assign DrawX       = draw_x_q;
    assign DrawY       = draw_y_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;
    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = vga_hs_q;
    assign VGA_VS      = vga_vs_q;
    assign VGA_BLANK_N = vga_blank_n_q;
    assign VGA_R       = rgb_q.r;
    assign VGA_G       = rgb_q.g;
    assign VGA_B       = rgb_q.b;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a shrunken 24x10 raster (12x5 visible).
module tb_vga_scan_gen;

    localparam int CD         = 2;
    localparam int HT         = 24;
    localparam int VT         = 10;
    localparam int FRAME_CLKS = CD * HT * VT;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  Red, Green, Blue;
    logic [9:0]  DrawX, DrawY;
    logic        pix_ce, frame_start;
    logic [15:0] frame_count;
    logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    always #5 Clk = ~Clk;

    vga_scan_gen #(
        .H_VISIBLE(12), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(5),  .V_FP(2), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(CD)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Red(Red), .Green(Green), .Blue(Blue),
        .DrawX(DrawX), .DrawY(DrawY),
        .pix_ce(pix_ce), .frame_start(frame_start), .frame_count(frame_count),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank_n;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } out_t;

    out_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    bit          running = 1'b0;
    int          c = 0;
    int          pat = 0;
    logic [15:0] fc_base = 16'd0;
    bit          prev_pix = 1'b0;
    int          k = 0;
    int          hs_low = 0, vis_cnt = 0, vs_low = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (c=%0d)", name, act, exp, c);
        end
    endtask

    // Stand-in for color_mapper: colour is a pure function of the coordinates.
    always_comb begin
        if (pat == 0) begin
            Red   = DrawX[7:0];
            Green = DrawY[7:0];
            Blue  = 8'hA5;
        end else begin
            Red   = ~DrawX[7:0];
            Green = DrawY[7:0] + 8'd1;
            Blue  = 8'h5A;
        end
    end

    // Producer: tracks the raster from its own cycle count and queues each pixel's output.
    always @(negedge Clk) begin
        if (running) begin
            int   p, x, y;
            bit   vis;
            out_t e;
            p = c / CD;
            x = p % HT;
            y = (p / HT) % VT;
            check("pix_ce", {31'd0, pix_ce}, {31'd0, (c % CD) == CD - 1});
            check("vga_clk", {31'd0, VGA_CLK}, {31'd0, (c > 0) && (((c - 1) % CD) >= CD / 2)});
            check("frame_start", {31'd0, frame_start}, {31'd0, (c > 0) && (c % FRAME_CLKS == 0)});
            check("frame_count", {16'd0, frame_count}, {16'd0, 16'(fc_base + c / FRAME_CLKS)});
            if (c % CD == 0) begin
                check("draw_x", {22'd0, DrawX}, x);
                check("draw_y", {22'd0, DrawY}, y);
                vis       = (x < 12) && (y < 5);
                e.hs      = !(x >= 15 && x <= 18);
                e.vs      = !(y >= 7 && y <= 8);
                e.blank_n = vis;
                e.r       = !vis ? 8'h00 : (pat == 0) ? 8'(x) : ~8'(x);
                e.g       = !vis ? 8'h00 : (pat == 0) ? 8'(y) : 8'(y + 1);
                e.b       = !vis ? 8'h00 : (pat == 0) ? 8'hA5 : 8'h5A;
                exp_q.push_back(e);
            end
            c++;
        end
    end

    // Monitor: after every pix_ce edge the DAC outputs hold one pixel; pop and compare.
    always @(negedge Clk) begin
        if (running) begin
            if (prev_pix) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got output, expected none queued");
                end else begin
                    out_t e;
                    int   row;
                    e = exp_q.pop_front();
                    check("vga_hs", {31'd0, VGA_HS}, {31'd0, e.hs});
                    check("vga_vs", {31'd0, VGA_VS}, {31'd0, e.vs});
                    check("vga_blank_n", {31'd0, VGA_BLANK_N}, {31'd0, e.blank_n});
                    check("vga_r", {24'd0, VGA_R}, {24'd0, e.r});
                    check("vga_g", {24'd0, VGA_G}, {24'd0, e.g});
                    check("vga_b", {24'd0, VGA_B}, {24'd0, e.b});
                    if (!VGA_HS) hs_low++;
                    if (VGA_BLANK_N) vis_cnt++;
                    if (!VGA_VS) vs_low++;
                    row = (k / HT) % VT;
                    if (k % HT == HT - 1) begin
                        check("hs_low_len", hs_low, 4);
                        check("visible_len", vis_cnt, (row < 5) ? 12 : 0);
                        hs_low  = 0;
                        vis_cnt = 0;
                    end
                    if (k % (HT * VT) == HT * VT - 1) begin
                        check("vs_low_len", vs_low, 2 * HT);
                        vs_low = 0;
                    end
                    k++;
                end
            end
            prev_pix = pix_ce;
        end
    end

    task automatic check_reset_values();
        check("rst_draw_x", {22'd0, DrawX}, 0);
        check("rst_draw_y", {22'd0, DrawY}, 0);
        check("rst_frame_count", {16'd0, frame_count}, 0);
        check("rst_pix_ce", {31'd0, pix_ce}, 0);
        check("rst_frame_start", {31'd0, frame_start}, 0);
        check("rst_vga_clk", {31'd0, VGA_CLK}, 0);
        check("rst_blank_n", {31'd0, VGA_BLANK_N}, 0);
        check("rst_hs", {31'd0, VGA_HS}, 1);
        check("rst_vs", {31'd0, VGA_VS}, 1);
        check("rst_rgb", {8'd0, VGA_R, VGA_G, VGA_B}, 0);
    endtask

    // Called at posedge+2 while reset has been sampled; restarts the scoreboard.
    task automatic release_reset(input int new_pat);
        Reset_n  = 1'b1;
        pat      = new_pat;
        c        = 0;
        k        = 0;
        hs_low   = 0;
        vis_cnt  = 0;
        vs_low   = 0;
        fc_base  = 16'd0;
        prev_pix = 1'b0;
        exp_q.delete();
        running  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        check_reset_values();
        release_reset(0);

        // Two full frames, then stop at pixel (7,3) of the third for a mid-frame reset.
        while (c < 2 * FRAME_CLKS + (3 * HT + 7) * CD + 1) @(posedge Clk);
        #2;
        check("pre_rst_draw_x", {22'd0, DrawX}, 7);
        check("pre_rst_draw_y", {22'd0, DrawY}, 3);
        running = 1'b0;
        Reset_n = 1'b0;
        @(posedge Clk);
        #2;
        check_reset_values();
        release_reset(1);

        // Preload the frame counter just below wrap partway through frame 1.
        while (c < FRAME_CLKS + 100) @(posedge Clk);
        #2;
        force dut.frame_count_q = 16'hFFFF;
        fc_base = 16'hFFFE;
        #1;
        release dut.frame_count_q;
        while (c <= 2 * FRAME_CLKS) @(posedge Clk);
        #2;
        check("frame_count_wrap", {16'd0, frame_count}, 0);

        while (c < 3 * FRAME_CLKS + 40) @(posedge Clk);
        #2;
        running = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
